// File: rtl/cp0_reg_pkg.sv
// CP0 register-file constants: register numbers, exception encodings, masks.
// Pure declarations, no timing.
// Shared by the CP0 block and anything that decodes its outputs.
package cp0_reg_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    // except_type encodings from the exception classifier
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    // Cause.ExcCode values
    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
    localparam logic [31:0] PRID_VALUE   = 32'h0000_4220;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    // IM[15:8], EXL[1], IE[0]
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    // software interrupt bits IP[1:0]
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // Maps a recognized exception encoding to its ExcCode; valid_o=0 otherwise.
    function automatic logic [5:0] exc_decode(input logic [31:0] t);
        logic [5:0] r;
        case (t)
            EXC_INT:  r = {1'b1, EXCCODE_INT};
            EXC_ADEL: r = {1'b1, EXCCODE_ADEL};
            EXC_ADES: r = {1'b1, EXCCODE_ADES};
            EXC_SYS:  r = {1'b1, EXCCODE_SYS};
            EXC_BP:   r = {1'b1, EXCCODE_BP};
            EXC_RI:   r = {1'b1, EXCCODE_RI};
            EXC_OV:   r = {1'b1, EXCCODE_OV};
            default:  r = 6'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// CP0 access bus: MTC0/MFC0 port, exception inputs, register and redirect outputs.
// Signal bundle only, no timing.
// No handshake; the pipeline drives every input each cycle.
interface cp0_reg_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] except_type_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic        timer_int_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output we_i, waddr_i, raddr_i, data_i, int_i, except_type_i,
               current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
        input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
               badvaddr_o, timer_int_o, flush_o, new_pc_o
    );

    modport slave (
        input  we_i, waddr_i, raddr_i, data_i, int_i, except_type_i,
               current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
        output data_o, count_o, compare_o, status_o, cause_o, epc_o,
               badvaddr_o, timer_int_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/cp0_reg.sv
// MIPS CP0 register file: timer, interrupt sampling, exception entry/ERET.
// Registers update one clock after inputs; data_o, flush_o, new_pc_o are combinational.
// No backpressure; every input is consumed in the cycle it is presented.
module cp0_reg
    import cp0_reg_pkg::*;
(
    input logic      clk,
    input logic      rst,
    cp0_reg_if.slave bus
);

    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic [31:0] status_q, status_d, cause_q, cause_d;
    logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic        tick_q, tick_d, timer_int_q, timer_int_d;

    // Register values after this cycle's MTC0 alone (also the read-bypass view)
    logic [31:0] count_w, compare_w, status_w, cause_w, epc_w;
    logic        wr_count, wr_compare;
    logic [5:0]  exc_dec;
    logic        exc_hit, eret_hit;

    assign exc_dec  = exc_decode(bus.except_type_i);
    assign exc_hit  = exc_dec[5];
    assign eret_hit = (bus.except_type_i == EXC_ERET);

    // Apply the MTC0 write with per-register write masks
    always_comb begin
        count_w    = count_q;
        compare_w  = compare_q;
        status_w   = status_q;
        cause_w    = cause_q;
        epc_w      = epc_q;
        wr_count   = 1'b0;
        wr_compare = 1'b0;
        if (bus.we_i) begin
            case (bus.waddr_i)
                CP0_COUNT:   begin count_w = bus.data_i; wr_count = 1'b1; end
                CP0_COMPARE: begin compare_w = bus.data_i; wr_compare = 1'b1; end
                CP0_STATUS:  status_w = (status_q & ~STATUS_WMASK) | (bus.data_i & STATUS_WMASK);
                CP0_CAUSE:   cause_w = (cause_q & ~CAUSE_WMASK) | (bus.data_i & CAUSE_WMASK);
                CP0_EPC:     epc_w = bus.data_i;
                default:     ;
            endcase
        end
    end

    // Next state: timer, interrupt sampling, then exception/ERET overriding the MTC0 view
    always_comb begin
        tick_d      = ~tick_q;
        count_d     = count_w;
        if (!wr_count && tick_q) begin
            count_d = count_q + 32'd1;
        end
        compare_d   = compare_w;
        timer_int_d = timer_int_q | ((count_q == compare_q) && (compare_q != 32'd0));
        if (wr_compare) begin
            timer_int_d = 1'b0;
        end
        status_d          = status_w;
        cause_d           = cause_w;
        cause_d[15:10]    = {bus.int_i[5] | timer_int_q, bus.int_i[4:0]};
        epc_d             = epc_w;
        badvaddr_d        = badvaddr_q;
        if (exc_hit) begin
            cause_d[6:2] = exc_dec[4:0];
            status_d[1]  = 1'b1;
            // Nested exceptions keep the original return address
            if (!status_q[1]) begin
                epc_d       = bus.is_in_delayslot_i ? (bus.current_inst_addr_i - 32'd4)
                                                    : bus.current_inst_addr_i;
                cause_d[31] = bus.is_in_delayslot_i;
            end
            if ((bus.except_type_i == EXC_ADEL) || (bus.except_type_i == EXC_ADES)) begin
                badvaddr_d = bus.bad_addr_i;
            end
        end else if (eret_hit) begin
            status_d[1] = 1'b0;
        end
    end

    // Read mux, flush and redirect target
    always_comb begin
        case (bus.raddr_i)
            CP0_BADVADDR: bus.data_o = badvaddr_q;
            CP0_COUNT:    bus.data_o = count_w;
            CP0_COMPARE:  bus.data_o = compare_w;
            CP0_STATUS:   bus.data_o = status_w;
            CP0_CAUSE:    bus.data_o = cause_w;
            CP0_EPC:      bus.data_o = epc_w;
            CP0_PRID:     bus.data_o = PRID_VALUE;
            default:      bus.data_o = 32'd0;
        endcase
        bus.flush_o  = !rst && (exc_hit || eret_hit);
        bus.new_pc_o = eret_hit ? epc_w : EXC_VECTOR;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            status_q    <= STATUS_RESET;
            cause_q     <= 32'd0;
            epc_q       <= 32'd0;
            badvaddr_q  <= 32'd0;
            tick_q      <= 1'b0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            status_q    <= status_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            badvaddr_q  <= badvaddr_d;
            tick_q      <= tick_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign bus.count_o     = count_q;
    assign bus.compare_o   = compare_q;
    assign bus.status_o    = status_q;
    assign bus.cause_o     = cause_q;
    assign bus.epc_o       = epc_q;
    assign bus.badvaddr_o  = badvaddr_q;
    assign bus.timer_int_o = timer_int_q;

endmodule
